sumador_pipeline: RTL and testbench
===================================

Name: sumador_pipeline

Overview:
- Parametrised, pipelined successor of the team's combinational 16-bit adder.
- Adds or subtracts two WIDTH-bit operands through a carry-segmented pipeline of STAGES registers.
- Produces sum, carry-out and signed overflow, with valid/ready handshakes on both sides.
- Sits between operand producers and the datapath result bus wherever the combinational adder no longer meets timing.

Parameters:
- WIDTH, 16, operand/result width in bits; legal 4..64.
- STAGES, 2, number of pipeline stages, which is also the latency in cycles; legal 1..4.
- WIDTH must be divisible by STAGES (elaboration check).

Ports:
- CLK  input  1  clock; all registers update on the rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- IN_VALID  input  1  operand beat valid.
- IN_READY  output  1  block can accept a beat this cycle.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- SUB  input  1  0 computes A+B; 1 computes A-B.
- OUT_VALID  output  1  result beat valid.
- OUT_READY  input  1  consumer accepts the result.
- OUT  output  WIDTH  result, mod 2^WIDTH.
- COUT  output  1  carry out of the MSB (for SUB: 1 means no borrow).
- OVF  output  1  two's-complement overflow.

Behaviour:
- Reset: RST_N low asynchronously clears every stage valid bit and all data registers. During reset and after release: OUT=0, COUT=0, OVF=0, OUT_VALID=0, IN_READY=1.
- Segmentation: with SEG=WIDTH/STAGES, stage k (k=0..STAGES-1) adds bits [k*SEG +: SEG] of A and Beff, plus the carry registered from stage k-1.
  - Beff = SUB ? ~B : B.
  - Carry into stage 0 = SUB.
  - Lower result segments and the upper unprocessed operand segments are carried forward in the stage registers.
- Latency: a beat accepted at edge t presents its result on OUT/COUT/OVF with OUT_VALID=1 after edge t+STAGES-1, if there is no stall.
- Advance: adv = !OUT_VALID || OUT_READY. When adv=1, every stage shifts by one, including bubbles (valid=0). When adv=0, all stages hold.
- IN_READY = adv. A beat is accepted when IN_VALID && IN_READY.
- Throughput: one beat per cycle while OUT_READY stays high.
- Output stability: while OUT_VALID=1 and OUT_READY=0, OUT, COUT and OVF hold stable.
- Flags:
  - COUT = carry out of bit WIDTH-1.
  - OVF = (A[MSB] == Beff[MSB]) && (OUT[MSB] != A[MSB]), computed in the final stage from the registered MSBs.
- Simultaneous events: a new beat accepted in the same cycle the consumer takes the output is legal and needs no bubble.
- Reset mid-operation: in-flight beats are discarded and are never presented on OUT.
- Inputs A, B, SUB are don't-care when IN_VALID=0. Bubble data is not required to be zero.

Optional Feature:
- Macro: SUMADOR_SAT_EN.
- Defined:
  - Adds input port SAT (1 bit), sampled and pipelined with each beat.
  - When SAT=1 and OVF=1, OUT clamps to the signed limit: 2^(WIDTH-1)-1 if A is non-negative, else -2^(WIDTH-1).
  - OVF still reports 1. COUT is unchanged.
- Undefined:
  - The SAT port does not exist.
  - OUT always wraps mod 2^WIDTH.

Test Plan (WIDTH=16, STAGES=2):
- Hold RST_N low, then release -> OUT_VALID=0, OUT=0, IN_READY=1. Assert RST_N low with 2 beats in flight -> those beats never appear on OUT.
- A=0x00FF, B=0x0001, SUB=0 (carry crosses the segment boundary) -> after 2 cycles, OUT=0x0100, COUT=0, OVF=0, OUT_VALID=1.
- A=0xFFFF, B=0x0001, SUB=0 -> OUT=0x0000, COUT=1, OVF=0. Then A=0x7FFF, B=0x0001 -> OUT=0x8000, OVF=1, COUT=0.
- A=0x0003, B=0x0005, SUB=1 -> OUT=0xFFFE, COUT=0. Then A=0x8000, B=0x0001, SUB=1 -> OUT=0x7FFF, OVF=1.
- Stream 8 back-to-back beats with OUT_READY held 0 for 3 cycles mid-stream -> IN_READY=0 during the stall, OUT holds stable, and all 8 results arrive in order with no loss or duplication.
- With SUMADOR_SAT_EN: A=0x7FFF, B=0x0001, SAT=1 -> OUT=0x7FFF, OVF=1. A=0x8000, B=0xFFFF, SAT=1 -> OUT=0x8000, OVF=1. Same operands with SAT=0 -> wrapped results.

Source files
------------

// File: rtl/sumador_pipeline.sv
// sumador_pipeline: carry-segmented pipelined add/sub with valid/ready; define SUMADOR_SAT_EN to add the SAT clamp port
module sumador_pipeline #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef SUMADOR_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;
    localparam int M   = WIDTH - 1;

    if (WIDTH < 4 || WIDTH > 64 || STAGES < 1 || STAGES > 4 || WIDTH % STAGES != 0) begin : g_bad_params
        $error("sumador_pipeline: illegal WIDTH/STAGES combination");
    end

    // ra/rb carry the operands forward, rr the result segments produced so far
    logic [STAGES-1:0][WIDTH-1:0] ra, rb, rr, na, nb, nr;
    logic [STAGES-1:0]            rv, rc, nv, ci, co;
    logic [SEG:0]                 t;
    logic                         adv;

    assign adv      = !rv[L] || out_ready;
    assign in_ready = adv;

    always_comb begin
        na[0] = a;
        nb[0] = sub ? ~b : b;
        nr[0] = '0;
        nv[0] = in_valid;
        ci[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            na[k] = ra[k-1];
            nb[k] = rb[k-1];
            nr[k] = rr[k-1];
            nv[k] = rv[k-1];
            ci[k] = rc[k-1];
        end
        co = '0;
        t  = '0;
        for (int k = 0; k < STAGES; k++) begin
            t = {1'b0, na[k][k*SEG +: SEG]} + {1'b0, nb[k][k*SEG +: SEG]} + {{SEG{1'b0}}, ci[k]};
            nr[k][k*SEG +: SEG] = t[SEG-1:0];
            co[k] = t[SEG];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv <= '0;
            rc <= '0;
            ra <= '0;
            rb <= '0;
            rr <= '0;
        end else if (adv) begin
            rv <= nv;
            rc <= co;
            ra <= na;
            rb <= nb;
            rr <= nr;
        end
    end

    assign out_valid = rv[L];
    assign cout      = rc[L];
    assign ovf       = (ra[L][M] == rb[L][M]) && (rr[L][M] != ra[L][M]);

`ifdef SUMADOR_SAT_EN
    logic [STAGES-1:0] rs, ns;

    always_comb begin
        ns[0] = sat;
        for (int k = 1; k < STAGES; k++) ns[k] = rs[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rs <= '0;
        else if (adv) rs <= ns;
    end

    assign out = (rs[L] && ovf) ? (ra[L][M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}}) : rr[L];
`else
    assign out = rr[L];
`endif
endmodule

// File: tb/tb_sumador_pipeline.sv
// tb_sumador_pipeline: directed and random checks of sumador_pipeline against a cycle-level beat model
module tb_sumador_pipeline;
    localparam int W = 16;
    localparam int S = 2;
`ifdef SUMADOR_SAT_EN
    localparam bit HAS_SAT = 1'b1;
`else
    localparam bit HAS_SAT = 1'b0;
`endif

    typedef struct packed {
        logic         v;
        logic [W-1:0] o;
        logic         c;
        logic         f;
    } ent_t;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] a = '0, b = '0, out;
`ifdef SUMADOR_SAT_EN
    logic         sat = 1'b0;
`endif

    int   n_vec = 0, n_err = 0, n_out = 0;
    ent_t pipe[$];

    always #5 clk = ~clk;

    sumador_pipeline #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .sub(sub),
`ifdef SUMADOR_SAT_EN
        .sat(sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .cout(cout),
        .ovf(ovf)
    );

    // Reference arithmetic on plain signed/unsigned integers
    function automatic ent_t model(input logic [W-1:0] x, y, input logic s, st);
        ent_t e;
        int   ix, iy, r;
        ix  = int'($signed(x));
        iy  = int'($signed(y));
        r   = s ? ix - iy : ix + iy;
        e.v = 1'b1;
        e.f = (r >= 2 ** (W - 1)) || (r < -(2 ** (W - 1)));
        e.c = s ? (x >= y) : ((int'(x) + int'(y)) >= 2 ** W);
        e.o = r[W-1:0];
        if (st && e.f) e.o = (ix < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_pipe();
        pipe.delete();
        repeat (S) pipe.push_back('0);
    endtask

    // One cycle: drive at the falling edge, check the beat at the head, advance the model
    task automatic step(input logic v, input logic [W-1:0] x, y, input logic s, st, r);
        ent_t e;
        in_valid  = v;
        a         = x;
        b         = y;
        sub       = s;
        out_ready = r;
`ifdef SUMADOR_SAT_EN
        sat       = st;
`endif
        #1;
        e = pipe[0];
        chk("out_valid", {15'd0, out_valid}, {15'd0, e.v});
        chk("in_ready", {15'd0, in_ready}, {15'd0, !e.v || r});
        if (e.v) begin
            chk("out", out, e.o);
            chk("cout", {15'd0, cout}, {15'd0, e.c});
            chk("ovf", {15'd0, ovf}, {15'd0, e.f});
        end
        if (!e.v || r) begin
            if (e.v) n_out++;
            pipe.delete(0);
            pipe.push_back(v ? model(x, y, s, st) : '0);
        end
        @(negedge clk);
    endtask

    task automatic directed(input logic [W-1:0] x, y, input logic s, st,
                            input logic [W-1:0] eo, input logic ec, ef);
        step(1'b1, x, y, s, st, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("dir_valid", {15'd0, out_valid}, 16'd1);
        chk("dir_out", out, eo);
        chk("dir_cout", {15'd0, cout}, {15'd0, ec});
        chk("dir_ovf", {15'd0, ovf}, {15'd0, ef});
    endtask

    initial begin
        int sent, n0;
        logic acc, v, r;
        reset_pipe();
        repeat (2) @(negedge clk);
        chk("rst_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out", out, 16'h0000);
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_cout", {15'd0, cout}, 16'd0);
        chk("rst_ovf", {15'd0, ovf}, 16'd0);
        rst_n = 1'b1;
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        chk("rel_out", out, 16'h0000);

        directed(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        directed(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`ifdef SUMADOR_SAT_EN
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        directed(16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
        directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`endif
        repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // 8 back-to-back beats with a 3-cycle consumer stall in the middle
        sent = 0;
        n0   = n_out;
        for (int i = 0; i < 14; i++) begin
            r   = !(i >= 4 && i <= 6);
            v   = sent < 8;
            acc = v && (!pipe[0].v || r);
            step(v, W'($urandom), W'($urandom), 1'($urandom), 1'b0, r);
            if (acc) sent++;
        end
        chk("stream_sent", W'(sent), 16'd8);
        chk("stream_recv", W'(n_out - n0), 16'd8);

        // Reset with two beats in flight: neither may surface afterwards
        step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4321, 16'h0101, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {15'd0, out_valid}, 16'd0);
        chk("midrst_out", out, 16'h0000);
        chk("midrst_ready", {15'd0, in_ready}, 16'd1);
        reset_pipe();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        repeat (300) step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 1'($urandom),
                          HAS_SAT && 1'($urandom), $urandom_range(0, 3) != 0);
        repeat (S + 1) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
